rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port between the pipeline writeback stage (primary) and a

---
 rtl/rf_arb_pkg.sv | 21 ++
 rtl/rf_arb_fifo.sv | 79 +++++++
 rtl/rf_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_arb_pkg : shared types for the register-file write-port arbiter       |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUEUED = 2'd1,
        FORCE  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        PIPE = 2'd1,
        AUX  = 2'd2
    } grant_src_e;

endpackage : rf_arb_pkg
`default_nettype wire

// File: rtl/rf_arb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_arb_fifo : sync FIFO of (addr,data) with per-entry address match      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic [ADDR_W-1:0]         push_addr_i,
    input  logic [DATA_W-1:0]         push_data_i,
    input  logic                      pop_i,
    input  logic [ADDR_W-1:0]         match_addr_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [ADDR_W-1:0]         head_addr_o,
    output logic [DATA_W-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [DEPTH-1:0]          match_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;

    always_comb begin
        valid_d = valid_q;
        if (do_pop)  valid_d[rd_ptr_q] = 1'b0;
        if (do_push) valid_d[wr_ptr_q] = 1'b1;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match_o[i] = valid_q[i] && (addr_q[i] == match_addr_i);
    end

endmodule : rf_arb_fifo
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_write_arbiter : shares the RF write port between WB and an aux queue  |
// | RFARB_BYPASS_EN: aux result skips an empty idle queue. rev 1.0           |
// +--------------------------------------------------------------------------+
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              pipe_stall,
    input  logic [ADDR_W-1:0] query_addr,
    output logic              query_pend
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_e        state_q, state_d;
    grant_src_e        grant;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] rf_data_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, bypass;
    logic [ADDR_W-1:0] fifo_head_addr, gnt_addr;
    logic [DATA_W-1:0] fifo_head_data, gnt_data;
    logic [CNT_W-1:0]  fifo_count, count_next;
    logic [FIFO_DEPTH-1:0] fifo_match;

    rf_arb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (fifo_push),
        .push_addr_i  (aux_addr),
        .push_data_i  (aux_data),
        .pop_i        (fifo_pop),
        .match_addr_i (query_addr),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_addr_o  (fifo_head_addr),
        .head_data_o  (fifo_head_data),
        .count_o      (fifo_count),
        .match_o      (fifo_match)
    );

    // No push-through: a full queue refuses even when it pops this cycle.
    assign aux_ready  = !reset && !fifo_full;
    assign pipe_stall = (state_q == FORCE);
    assign query_pend = (query_addr != '0) && (|fifo_match);
    assign fifo_push  = aux_valid && aux_ready && !bypass;
    assign count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    always_comb begin
        grant    = NONE;
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        gnt_addr = pipe_addr;
        gnt_data = pipe_data;
        if (state_q == FORCE) begin
            if (!fifo_empty) begin
                grant    = AUX;
                fifo_pop = 1'b1;
                gnt_addr = fifo_head_addr;
                gnt_data = fifo_head_data;
            end
        end else if (pipe_we) begin
            grant = PIPE;
        end else if (!fifo_empty) begin
            grant    = AUX;
            fifo_pop = 1'b1;
            gnt_addr = fifo_head_addr;
            gnt_data = fifo_head_data;
        end
`ifdef RFARB_BYPASS_EN
        else if (aux_valid) begin
            grant    = AUX;
            bypass   = 1'b1;
            gnt_addr = aux_addr;
            gnt_data = aux_data;
        end
`endif
    end

    always_comb begin
        if (fifo_empty || fifo_pop)
            wait_d = '0;
        else if (wait_q == WAIT_W'(MAX_WAIT))
            wait_d = wait_q;
        else
            wait_d = wait_q + 1'b1;
    end

    // The drain is forced on the edge that latches the saturated wait count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_push) state_d = QUEUED;
            QUEUED: begin
                if (wait_d == WAIT_W'(MAX_WAIT)) state_d = FORCE;
                else if (count_next == '0)       state_d = IDLE;
            end
            FORCE:   state_d = (count_next == '0) ? IDLE : QUEUED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rf_we_q <= (grant != NONE) && (gnt_addr != '0);
            if (grant != NONE) begin
                rf_addr_q <= gnt_addr;
                rf_data_q <= gnt_data;
            end
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rf_write_arbiter : directed + random bench with a queue-based model   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rf_write_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
`ifdef RFARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, pipe_we, aux_valid, aux_ready;
    logic [ADDR_W-1:0] pipe_addr, aux_addr, query_addr, rf_addr;
    logic [DATA_W-1:0] pipe_data, aux_data, rf_data;
    logic              rf_we, pipe_stall, query_pend;

    rf_write_arbiter #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .FIFO_DEPTH (DEPTH), .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk), .reset (reset),
        .pipe_we (pipe_we), .pipe_addr (pipe_addr), .pipe_data (pipe_data),
        .aux_valid (aux_valid), .aux_ready (aux_ready), .aux_addr (aux_addr), .aux_data (aux_data),
        .rf_we (rf_we), .rf_addr (rf_addr), .rf_data (rf_data),
        .pipe_stall (pipe_stall), .query_addr (query_addr), .query_pend (query_pend)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    int tests = 0;
    int fails = 0;
    ent_t mq[$];            // model queue contents, head at index 0
    int   age;              // cycles the model head has waited ungranted
    bit   m_force;          // model: next cycle is a forced drain
    logic [ADDR_W-1:0] wlog[$];
    bit   obs_stall, obs_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_pend();
        if (query_addr == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == query_addr) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check comb outputs, advance the model, check registered outputs.
    task automatic cycle();
        bit   granted, popped, had_head, ready_m, bypassed, was_reset;
        ent_t g;
        #1;
        ready_m = !reset && (mq.size() < DEPTH);
        chk("aux_ready", aux_ready, ready_m);
        chk("pipe_stall", pipe_stall, m_force);
        chk("query_pend", query_pend, exp_pend());
        obs_stall = pipe_stall;
        obs_ready = aux_ready;
        granted = 0; popped = 0; bypassed = 0; g = '0;
        had_head  = (mq.size() > 0);
        was_reset = reset;
        if (reset) begin
            mq.delete();
            age = 0;
            m_force = 0;
        end else begin
            if (m_force) begin
                if (had_head) begin g = mq.pop_front(); granted = 1; popped = 1; end
            end else if (pipe_we) begin
                g.a = pipe_addr; g.d = pipe_data; granted = 1;
            end else if (had_head) begin
                g = mq.pop_front(); granted = 1; popped = 1;
            end else if (BYP && aux_valid) begin
                g.a = aux_addr; g.d = aux_data; granted = 1; bypassed = 1;
            end
            if (aux_valid && ready_m && !bypassed) begin
                ent_t n;
                n.a = aux_addr; n.d = aux_data;
                mq.push_back(n);
            end
            if (had_head && !popped) age = (age < MAX_WAIT) ? age + 1 : MAX_WAIT;
            else age = 0;
            m_force = (age == MAX_WAIT);
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, granted && (g.a != '0));
        if (granted && g.a != '0) begin
            chk("rf_addr", rf_addr, g.a);
            chk("rf_data", rf_data, g.d);
        end
        if (was_reset) begin
            chk("rst_rf_addr", rf_addr, 0);
            chk("rst_rf_data", rf_data, 0);
        end
        if (rf_we === 1'b1) wlog.push_back(rf_addr);
    endtask

    task automatic reset_dut();
        reset = 1; pipe_we = 0; aux_valid = 0;
        cycle();
        reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, idx, n, stalls;
        bit saw_block;
        int e3[9] = '{1, 2, 3, 4, 5, 20, 6, 7, 8};
        int auxw[$];

        reset = 1; pipe_we = 0; pipe_addr = '0; pipe_data = '0;
        aux_valid = 0; aux_addr = '0; aux_data = '0; query_addr = '0;
        age = 0; m_force = 0;
        cycle();
        cycle();
        chk("rst_we", rf_we, 0);
        chk("rst_stall", pipe_stall, 0);
        reset = 0;

        // pipeline write appears one cycle later
        pipe_we = 1; pipe_addr = 5; pipe_data = 32'hA5A5A5A5;
        cycle();
        chk("t1_we", rf_we, 1);
        chk("t1_addr", rf_addr, 5);
        chk("t1_data", rf_data, 32'hA5A5A5A5);

        // single aux result through the queue (or bypass)
        pipe_we = 0; aux_valid = 1; aux_addr = 9; aux_data = 32'h123; query_addr = 9;
        cycle();
        aux_valid = 0;
        chk("t2_we_n1", rf_we, BYP);
        chk("t2_pend_queued", query_pend, !BYP);
        cycle();
        chk("t2_we_n2", rf_we, !BYP);
        chk("t2_addr", rf_addr, 9);
        chk("t2_pend_gone", query_pend, 0);

        // starvation guard: one forced drain, WB holds then resumes
        reset_dut();
        wlog.delete();
        p = 1; stalls = 0;
        pipe_we = 1; aux_valid = 1; aux_addr = 20; aux_data = 32'h77;
        for (int k = 0; k < 9; k++) begin
            pipe_addr = ADDR_W'(p); pipe_data = DATA_W'(p * 3);
            cycle();
            aux_valid = 0;
            if (obs_stall) stalls++;
            else p++;
        end
        chk("t3_stall_cycles", stalls, 1);
        chk("t3_writes", wlog.size(), 9);
        for (int k = 0; k < 9; k++)
            chk("t3_order", (k < wlog.size()) ? wlog[k] : '1, e3[k]);

        // back-pressure with DEPTH=2 and in-order drain
        reset_dut();
        wlog.delete();
        pipe_we = 1; pipe_addr = 1; idx = 0; saw_block = 0;
        for (int k = 0; k < 20; k++) begin
            aux_valid = (idx < 3);
            aux_addr  = ADDR_W'(11 + idx);
            aux_data  = DATA_W'(idx);
            cycle();
            if (aux_valid && obs_ready) idx++;
            else if (aux_valid && idx == 2) saw_block = 1;
        end
        aux_valid = 0;
        chk("t4_third_blocked", saw_block, 1);
        chk("t4_all_accepted", idx, 3);
        foreach (wlog[i]) if (wlog[i] >= 11) auxw.push_back(int'(wlog[i]));
        chk("t4_aux_count", auxw.size(), 3);
        for (int k = 0; k < 3; k++)
            chk("t4_aux_order", (k < auxw.size()) ? auxw[k] : 0, 11 + k);

        // address 0: grant consumed, no write, slot still occupied
        reset_dut();
        pipe_we = 1; pipe_addr = 0; pipe_data = 32'hFF;
        cycle();
        chk("t5_pipe_a0", rf_we, 0);
        pipe_addr = 1; aux_valid = 1; aux_addr = 0;
        cycle();
        cycle();
        aux_valid = 0; pipe_we = 0;
        cycle();
        chk("t5_full_a0", obs_ready, 0);
        chk("t5_drain_a0", rf_we, 0);
        cycle();
        chk("t5_count_dec", obs_ready, 1);
        chk("t5_drain2_a0", rf_we, 0);

        // reset during a forced drain with two entries queued
        reset_dut();
        pipe_we = 1; pipe_addr = 2; aux_valid = 1; aux_addr = 3;
        cycle();
        aux_addr = 4;
        cycle();
        aux_valid = 0;
        n = 0;
        while (!m_force && n < 20) begin cycle(); n++; end
        chk("t6_force_reached", m_force, 1);
        reset = 1; query_addr = 3;
        cycle();
        chk("t6_stall", pipe_stall, 0);
        chk("t6_pend", query_pend, 0);
        chk("t6_we", rf_we, 0);
        reset = 0; pipe_we = 0;
        wlog.delete();
        repeat (6) cycle();
        chk("t6_no_drain", wlog.size(), 0);

        // randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            reset      = ($urandom_range(0, 63) == 0);
            pipe_we    = 1'($urandom_range(0, 1));
            pipe_addr  = ADDR_W'($urandom_range(0, 7));
            pipe_data  = $urandom;
            aux_valid  = ($urandom_range(0, 9) < 4);
            aux_addr   = ADDR_W'($urandom_range(0, 7));
            aux_data   = $urandom;
            query_addr = ADDR_W'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rf_write_arbiter
`default_nettype wire
